uart_rx: RTL and testbench

Asynchronous serial receiver for the breadboard computer's console link. It samples an 8N1 line (start bit, 8 data bits LSB-first, one stop bit), reassembles each byte in an internal right-shift register, and presents it to the Z80-side bus logic through a valid/acknowledge holding register with framing and overrun status. It is the receive end of the serial link whose transmit side frames and shifts out bytes with 1-padding.

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 serial receiver with valid/ack holding register, framing
//            error pulse and sticky overrun flag for the console link.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int DATA_BITS      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_ack,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_overrun,
  output logic                 o_frame_error,
  output logic                 o_busy
);

  localparam int c_CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_CNT_W-1:0] c_HALF_M1  = c_CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_M1  = c_CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_next;
  logic                 w_cnt_zero;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_IDX_W-1:0]   w_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_stop_good;
  logic                 w_stop_bad;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_frame_error;

  assign w_rx_s     = r_sync2;
  assign w_cnt_zero = (r_cnt == '0);

  // Both synchronizer flops reset to the idle (high) line level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_cnt_next   = c_HALF_M1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_cnt_zero) begin
          if (w_rx_s) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DATA;
            w_cnt_next   = c_FULL_M1;
            w_idx_next   = '0;
          end
        end else begin
          w_cnt_next = r_cnt - c_CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_cnt_zero) begin
          // LSB-first line order: each new bit enters at the top and moves down.
          w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_cnt_next   = c_FULL_M1;
          if (r_idx == c_LAST_IDX) begin
            w_state_next = S_STOP;
          end else begin
            w_idx_next = r_idx + c_IDX_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt - c_CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
          // Leaving at mid-stop lets a back-to-back start edge be caught.
          if (w_rx_s) begin
            w_stop_good  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_state_next = S_BREAK;
          end
        end else begin
          w_cnt_next = r_cnt - c_CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (w_rx_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Later assignments win: a completion in the same cycle as an ack reloads.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= w_stop_bad;
      if (i_ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_stop_good) begin
        if (!r_valid || i_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign o_data        = r_data;
  assign o_valid       = r_valid;
  assign o_overrun     = r_overrun;
  assign o_frame_error = r_frame_error;
  assign o_busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Scoreboard bench for uart_rx: clean, glitch, framing, overrun,
//            back-to-back and mid-frame reset scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int C       = 16;
  localparam int LATENCY = 2 + C / 2 + 9 * C + 1;

  typedef struct {
    logic [7:0] data;
    int         due;
    bit         rise;
  } sb_t;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_ack;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_overrun;
  logic       o_frame_error;
  logic       o_busy;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  fe_cnt = 0;
  bit  ovr_seen = 1'b0;
  bit  prev_valid = 1'b0;
  sb_t sb[$];

  uart_rx #(.CLOCKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx         (i_rx),
    .i_ack        (i_ack),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_overrun    (o_overrun),
    .o_frame_error(o_frame_error),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit exp_byte,
                            input bit rise);
    sb_t e;
    if (exp_byte) begin
      e.data = b;
      e.due  = cyc + LATENCY;
      e.rise = rise;
      sb.push_back(e);
    end
    i_rx = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (C) tick();
    end
    i_rx = stop;
    repeat (C) tick();
  endtask

  task automatic ack_pulse();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  task automatic ack_at(input int n);
    while (cyc < n) tick();
    ack_pulse();
  endtask

  // Output monitor: pops the scoreboard when a byte is due.
  always @(negedge clk) begin
    sb_t e;
    if (sb.size() > 0 && cyc == sb[0].due) begin
      e = sb.pop_front();
      chk("sb_valid", {31'd0, o_valid}, 32'd1);
      chk("sb_data", {24'd0, o_data}, {24'd0, e.data});
      if (e.rise) chk("sb_rise_prev", {31'd0, prev_valid}, 32'd0);
    end
    if (o_frame_error) fe_cnt++;
    if (o_overrun) ovr_seen = 1'b1;
    prev_valid = o_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    i_reset = 1'b1;
    i_rx    = 1'b1;
    i_ack   = 1'b0;
    repeat (3) tick();
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
    chk("rst_frame_err", {31'd0, o_frame_error}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    i_reset = 1'b0;
    repeat (5) tick();

    // Clean 0xA5, held until ack.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    repeat (10) tick();
    chk("a5_held", {31'd0, o_valid}, 32'd1);
    ack_pulse();
    chk("a5_ack_clr", {31'd0, o_valid}, 32'd0);
    chk("a5_busy_idle", {31'd0, o_busy}, 32'd0);

    // Glitch: 5 low cycles is a false start.
    repeat (10) tick();
    k = cyc;
    i_rx = 1'b0;
    repeat (5) tick();
    chk("glitch_busy_up", {31'd0, o_busy}, 32'd1);
    i_rx = 1'b1;
    while (cyc < k + 11) tick();
    chk("glitch_busy_down", {31'd0, o_busy}, 32'd0);
    repeat (200) tick();
    chk("glitch_no_valid", {31'd0, o_valid}, 32'd0);
    chk("glitch_no_fe", fe_cnt, 32'd0);

    // Framing error with long break, then a good byte.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40) tick();
    i_rx = 1'b1;
    repeat (20) tick();
    chk("fe_one_pulse", fe_cnt, 32'd1);
    chk("fe_no_valid", {31'd0, o_valid}, 32'd0);
    chk("fe_busy_idle", {31'd0, o_busy}, 32'd0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    repeat (5) tick();
    ack_pulse();

    // Overrun: second byte dropped while first unacknowledged.
    repeat (10) tick();
    send_frame(8'h11, 1'b1, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    chk("ovr_data_kept", {24'd0, o_data}, 32'h11);
    chk("ovr_flag", {31'd0, o_overrun}, 32'd1);
    chk("ovr_valid", {31'd0, o_valid}, 32'd1);
    ack_pulse();
    chk("ovr_ack_valid", {31'd0, o_valid}, 32'd0);
    chk("ovr_ack_flag", {31'd0, o_overrun}, 32'd0);

    // Back-to-back frames, ack coinciding with each completion.
    repeat (10) tick();
    ovr_seen = 1'b0;
    k = cyc;
    fork
      begin
        send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
      end
      begin
        ack_at(k + LATENCY - 1);
        ack_at(k + 10 * C + LATENCY - 1);
      end
    join
    repeat (5) tick();
    chk("b2b_valid", {31'd0, o_valid}, 32'd1);
    chk("b2b_no_overrun", {31'd0, ovr_seen}, 32'd0);
    ack_pulse();
    chk("b2b_ack_clr", {31'd0, o_valid}, 32'd0);

    // Reset during data bit 4 of 0x5A, then a clean 0x81.
    repeat (10) tick();
    k = cyc;
    i_rx = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 4; i++) begin
      i_rx = (8'h5A >> i) & 8'h01;
      repeat (C) tick();
    end
    i_rx = 1'b1;
    repeat (5) tick();
    chk("mid_busy", {31'd0, o_busy}, 32'd1);
    i_reset = 1'b1;
    tick();
    chk("mid_rst_data", {24'd0, o_data}, 32'd0);
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_overrun", {31'd0, o_overrun}, 32'd0);
    chk("mid_rst_fe", {31'd0, o_frame_error}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    i_reset = 1'b0;
    repeat (40) tick();
    chk("mid_after_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_after_valid", {31'd0, o_valid}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    repeat (5) tick();
    ack_pulse();
    chk("end_valid", {31'd0, o_valid}, 32'd0);

    repeat (20) tick();
    chk("end_fe_total", fe_cnt, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
